// File: rtl/cim_pkg.sv
// Shared CIM definitions: state typedefs for the func unit and the
// input buffer, plus the sizing helpers used to derive tile counts.
package cim_pkg;

    typedef enum logic [1:0] {
        s_ibuf_fill,
        s_ibuf_full,
        s_ibuf_send,
        s_ibuf_start
    } t_ibuf_state;

    typedef enum logic [1:0] {
        s_func_idle,
        s_func_acc,
        s_func_act,
        s_func_out
    } t_func_state;

    // Tiles needed to cover num rows/cols with den-sized crossbars.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ibuf_bitplane_mux.sv
// Picks bit bit_sel of every stored activation and lays the result out
// as one crossbar row vector per vertical tile; rows past input_size are 0.
// Ports: elems (stored activations), bit_sel (plane index), plane (rows).
module ibuf_bitplane_mux
    import cim_pkg::*;
#(
    parameter int input_size    = 512,
    parameter int xbar_size     = 256,
    parameter int datatype_size = 8,
    parameter int v_cim_tiles   = 2,
    localparam int bit_w        = idx_width(datatype_size)
) (
    input  logic [datatype_size-1:0]          elems [input_size],
    input  logic [bit_w-1:0]                  bit_sel,
    output logic [v_cim_tiles-1:0][xbar_size-1:0] plane
);

    for (genvar t = 0; t < v_cim_tiles; t++) begin : g_tile
        for (genvar r = 0; r < xbar_size; r++) begin : g_row
            localparam int k = t * xbar_size + r;
            if (k < input_size) begin : g_live
                assign plane[t][r] = elems[k][bit_sel];
            end else begin : g_pad
                assign plane[t][r] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fc_ibuf.sv
// MLP layer input buffer: gathers one activation vector from the upstream
// func unit, then streams it LSB-first as bit planes to the CIM tiles.
// Ports: clk/rst; i_valid/i_data/o_busy (upstream); i_cim_busy,
// o_cim_valid/o_cim_bit_idx/o_cim_data/o_cim_start (CIM side).
module fc_ibuf
    import cim_pkg::*;
#(
    parameter int input_size    = 512,
    parameter int xbar_size     = 256,
    parameter int datatype_size = 8,
    localparam int v_cim_tiles  = ceil_div(input_size, xbar_size),
    localparam int bit_w        = idx_width(datatype_size)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic [datatype_size-1:0]              i_data,
    output logic                                  o_busy,
    input  logic                                  i_cim_busy,
    output logic                                  o_cim_valid,
    output logic [bit_w-1:0]                      o_cim_bit_idx,
    output logic [v_cim_tiles-1:0][xbar_size-1:0] o_cim_data,
    output logic                                  o_cim_start
);

    localparam int ptr_w = idx_width(input_size);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(input_size - 1);
    localparam logic [bit_w-1:0] last_bit = bit_w'(datatype_size - 1);

    t_ibuf_state state, state_next;
    logic [ptr_w-1:0] ptr, ptr_next;
    logic [bit_w-1:0] cnt, cnt_next;
    logic wr_en;

    logic [datatype_size-1:0] mem [input_size];
    logic [v_cim_tiles-1:0][xbar_size-1:0] plane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= s_ibuf_fill;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            cnt   <= cnt_next;
        end
    end

    // Storage is deliberately left out of reset: every element is
    // rewritten before a vector is ever sent.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= i_data;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        cnt_next   = cnt;
        wr_en      = 1'b0;
        unique case (state)
            s_ibuf_fill: begin
                if (i_valid) begin
                    wr_en = 1'b1;
                    if (ptr == last_ptr) begin
                        ptr_next   = '0;
                        state_next = s_ibuf_full;
                    end else begin
                        ptr_next = ptr + ptr_w'(1);
                    end
                end
            end
            s_ibuf_full: begin
                if (!i_cim_busy) begin
                    state_next = s_ibuf_send;
                    cnt_next   = '0;
                end
            end
            s_ibuf_send: begin
                // The plane burst never stalls, whatever the CIM says.
                if (cnt == last_bit) begin
                    state_next = s_ibuf_start;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + bit_w'(1);
                end
            end
            s_ibuf_start: begin
                state_next = s_ibuf_fill;
                ptr_next   = '0;
            end
            default: begin
                state_next = s_ibuf_fill;
                ptr_next   = '0;
                cnt_next   = '0;
            end
        endcase
    end

    assign o_busy = (state != s_ibuf_fill);

    // The mux looks at the plane the next state will present, so the
    // output registers carry it in the same cycle the state does.
    ibuf_bitplane_mux #(
        .input_size    (input_size),
        .xbar_size     (xbar_size),
        .datatype_size (datatype_size),
        .v_cim_tiles   (v_cim_tiles)
    ) u_mux (
        .elems   (mem),
        .bit_sel (cnt_next),
        .plane   (plane)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            o_cim_valid   <= 1'b0;
            o_cim_bit_idx <= '0;
            o_cim_data    <= '0;
            o_cim_start   <= 1'b0;
        end else begin
            o_cim_valid   <= (state_next == s_ibuf_send);
            o_cim_bit_idx <= (state_next == s_ibuf_send) ? cnt_next : '0;
            o_cim_data    <= (state_next == s_ibuf_send) ? plane : '0;
            o_cim_start   <= (state_next == s_ibuf_start);
        end
    end

endmodule

// File: tb/tb_fc_ibuf.sv
// Bench for fc_ibuf: a 512-element instance (exact tile multiple) and a
// 257-element instance (padded last tile), checked against a vector model.
module tb_fc_ibuf;

    localparam int D = 8;
    localparam int X = 256;
    localparam int V = 2;

    logic clk = 1'b0;
    logic rst;

    logic va, vb;
    logic [7:0] da, db;
    logic busy_a, busy_b;
    logic cbusy_a, cbusy_b;
    logic cv_a, cv_b;
    logic [2:0] idx_a, idx_b;
    logic [V-1:0][X-1:0] cd_a, cd_b;
    logic st_a, st_b;

    always #5 clk = ~clk;

    fc_ibuf #(
        .input_size(512), .xbar_size(X), .datatype_size(D)
    ) dut_a (
        .clk(clk), .rst(rst),
        .i_valid(va), .i_data(da), .o_busy(busy_a),
        .i_cim_busy(cbusy_a), .o_cim_valid(cv_a),
        .o_cim_bit_idx(idx_a), .o_cim_data(cd_a),
        .o_cim_start(st_a)
    );

    fc_ibuf #(
        .input_size(257), .xbar_size(X), .datatype_size(D)
    ) dut_b (
        .clk(clk), .rst(rst),
        .i_valid(vb), .i_data(db), .o_busy(busy_b),
        .i_cim_busy(cbusy_b), .o_cim_valid(cv_b),
        .o_cim_bit_idx(idx_b), .o_cim_data(cd_b),
        .o_cim_start(st_b)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name,
                         input logic [511:0] act,
                         input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Vector-level model: which vector is being collected, when the CIM
    // was found idle, and how many edges have elapsed since then.
    int n = 0;
    int size [2] = '{512, 257};
    bit coll [2] = '{1'b1, 1'b1};
    int cnt  [2] = '{0, 0};
    int go   [2] = '{-1, -1};
    bit was_rst [2] = '{1'b0, 1'b0};
    logic [7:0] mv [2][512];

    initial begin
        logic m_v [2];
        logic [7:0] m_d [2];
        logic m_b [2];
        int j;
        bit e_valid, e_start;
        logic [511:0] ep, a_cd;
        logic a_busy, a_cv, a_st;
        logic [2:0] a_idx;
        forever begin
            @(posedge clk);
            n++;
            m_v[0] = va; m_d[0] = da; m_b[0] = cbusy_a;
            m_v[1] = vb; m_d[1] = db; m_b[1] = cbusy_b;
            for (int i = 0; i < 2; i++) begin
                was_rst[i] = rst;
                if (rst) begin
                    coll[i] = 1'b1; cnt[i] = 0; go[i] = -1;
                end else if (coll[i]) begin
                    if (m_v[i]) begin
                        mv[i][cnt[i]] = m_d[i];
                        cnt[i]++;
                        if (cnt[i] == size[i]) coll[i] = 1'b0;
                    end
                end else if (go[i] < 0) begin
                    if (!m_b[i]) go[i] = n;
                end else if (n - go[i] == D + 1) begin
                    coll[i] = 1'b1; cnt[i] = 0; go[i] = -1;
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                j = (go[i] >= 0) ? n - go[i] : -1;
                e_valid = (j >= 0) && (j < D);
                e_start = (j == D);
                ep = '0;
                if (e_valid)
                    for (int k = 0; k < 512; k++)
                        if (k < size[i]) ep[k] = mv[i][k][j];
                a_busy = (i == 0) ? busy_a : busy_b;
                a_cv   = (i == 0) ? cv_a   : cv_b;
                a_st   = (i == 0) ? st_a   : st_b;
                a_idx  = (i == 0) ? idx_a  : idx_b;
                a_cd   = (i == 0) ? cd_a   : cd_b;
                check($sformatf("busy[%0d]", i), a_busy, !coll[i]);
                check($sformatf("valid[%0d]", i), a_cv, e_valid);
                check($sformatf("start[%0d]", i), a_st, e_start);
                if (e_valid || was_rst[i]) begin
                    check($sformatf("idx[%0d]", i), a_idx,
                          e_valid ? j : 0);
                    check($sformatf("plane[%0d]", i), a_cd, ep);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no summary, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, waited, planes;
        bit seen;
        rst = 1'b1;
        va = 1'b0; vb = 1'b0; da = '0; db = '0;
        cbusy_a = 1'b0; cbusy_b = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_valid", cv_a, 1'b0);
        check("rst_idx", idx_a, 3'd0);
        check("rst_data", cd_a, '0);
        check("rst_start", st_a, 1'b0);
        rst = 1'b0;

        // Vector 1: k mod 256, then 0xAA pressed on a busy buffer.
        w = 0;
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            va = 1'b1; da = 8'(k);
            if (k == 511) w = n;
        end
        @(negedge clk);
        da = 8'hAA;
        check("busy_after_last", busy_a, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (cv_a && idx_a == 3'd0) begin
                check("t1r3_b0", cd_a[1][3], 1'b1);
                check("t1r0_b0", cd_a[1][0], 1'b0);
                check("t0r255_b0", cd_a[0][255], 1'b1);
            end
            if (cv_a && idx_a == 3'd1)
                check("elem0_kept_b1", cd_a[0][0], 1'b0);
            if (st_a) begin
                seen = 1'b1;
                check("start_latency", n - w, 10);
            end
        end
        check("start1_seen", seen, 1'b1);

        // First fill cycle after start: accepted at pointer 0.
        @(negedge clk);
        da = 8'h5A;
        check("fill_after_start", busy_a, 1'b0);

        // Vector 2: gapped writes, CIM busy while it completes.
        for (int k = 1; k < 512; k++) begin
            @(negedge clk);
            va = 1'b0;
            @(negedge clk);
            va = 1'b1; da = 8'(k * 37 + 11);
            if (k == 511) begin
                check("busy_before_last", busy_a, 1'b0);
                cbusy_a = 1'b1;
            end
        end
        @(negedge clk);
        va = 1'b0;
        check("busy_after_gapped", busy_a, 1'b1);
        repeat (20) begin
            @(negedge clk);
            check("hold_valid", cv_a, 1'b0);
            check("hold_busy", busy_a, 1'b1);
        end
        cbusy_a = 1'b0;
        waited = 0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            waited++;
            if (cv_a) begin
                seen = 1'b1;
                check("first_plane_idx", idx_a, 3'd0);
                check("edges_from_last_busy", waited + 1, 2);
            end
        end
        check("plane2_seen", seen, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (cv_a && idx_a == 3'd1)
                check("elem0_5a_b1", cd_a[0][0], 1'b1);
            if (st_a) seen = 1'b1;
        end
        check("start2_seen", seen, 1'b1);

        // Padding: 257 elements of 0xFF on the second instance.
        for (int k = 0; k < 257; k++) begin
            @(negedge clk);
            vb = 1'b1; db = 8'hFF;
        end
        @(negedge clk);
        vb = 1'b0;
        planes = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (cv_b) begin
                planes++;
                check("pad_t1", cd_b[1], 256'h1);
                check("pad_t0", cd_b[0], {256{1'b1}});
            end
            if (st_b) seen = 1'b1;
            @(negedge clk);
        end
        check("pad_start_seen", seen, 1'b1);
        check("pad_planes", planes, 8);

        // Reset in the middle of a plane burst.
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            va = 1'b1; da = 8'(k) ^ 8'h3C;
        end
        @(negedge clk);
        va = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (cv_a && idx_a == 3'd3) seen = 1'b1;
            else @(negedge clk);
        end
        check("plane3_seen", seen, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid", cv_a, 1'b0);
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_start", st_a, 1'b0);
        repeat (15) begin
            @(negedge clk);
            check("no_start_after_rst", st_a, 1'b0);
        end

        // A full vector after the reset sends from bit 0.
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            va = 1'b1; da = 8'(k * 3);
        end
        @(negedge clk);
        va = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (cv_a) begin
                seen = 1'b1;
                check("post_rst_idx0", idx_a, 3'd0);
            end
        end
        check("post_rst_plane_seen", seen, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (st_a) seen = 1'b1;
        end
        check("post_rst_start_seen", seen, 1'b1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
